// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : UART receive framing engine - sync, oversample tick, start/data/
//            parity/stop sampling, byte hand-off on a valid/ready interface.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_TW = $clog2(OVERSAMPLE);
    localparam int c_BW = $clog2(DATA_BITS + 1);
    localparam logic [c_TW-1:0] c_MID_START = c_TW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TW-1:0] c_LAST_TICK = c_TW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_LAST_BIT  = c_BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_s_d;
    logic [DIV_W-1:0]     r_pre;
    logic [DIV_W-1:0]     r_div_m1;
    logic [c_TW-1:0]      r_tick_cnt;
    logic [c_BW-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_par_bad;

    logic w_start_edge;
    logic w_tick;
    logic w_mid;
    logic w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_rx_s   <= 1'b1;
            r_rx_s_d <= 1'b1;
        end else begin
            r_sync1  <= rx_in;
            r_rx_s   <= r_sync1;
            r_rx_s_d <= r_rx_s;
        end
    end

    assign w_start_edge = (r_state == S_IDLE) && r_rx_s_d && !r_rx_s;
    assign w_tick       = (r_state != S_IDLE) && (r_pre == r_div_m1);
    // The start bit is sampled half a bit in; the phase is then re-zeroed so
    // every later bit is sampled a full bit period after the previous one.
    assign w_mid        = w_tick && ((r_state == S_START) ? (r_tick_cnt == c_MID_START)
                                                          : (r_tick_cnt == c_LAST_TICK));
    assign w_done       = (r_state == S_STOP) && w_mid;
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_mid) begin
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_mid && (r_bit_cnt == c_LAST_BIT)) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_mid) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_mid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre      <= '0;
            r_div_m1   <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_par_bad  <= 1'b0;
        end else if (w_start_edge) begin
            r_pre      <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_div_m1   <= (baud_div == '0) ? '0 : (baud_div - DIV_W'(1));
            r_par_en   <= parity_en;
            r_par_odd  <= parity_odd;
            r_par_bad  <= 1'b0;
        end else if (r_state != S_IDLE) begin
            if (w_tick) begin
                r_pre <= '0;
                if ((r_state == S_START) && w_mid) begin
                    r_tick_cnt <= '0;
                end else if (r_tick_cnt == c_LAST_TICK) begin
                    r_tick_cnt <= '0;
                end else begin
                    r_tick_cnt <= r_tick_cnt + c_TW'(1);
                end
            end else begin
                r_pre <= r_pre + DIV_W'(1);
            end
            if (w_mid && (r_state == S_DATA)) begin
                r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + c_BW'(1);
            end
            if (w_mid && (r_state == S_PARITY)) begin
                r_par_bad <= ((^r_shift) ^ r_rx_s) != r_par_odd;
            end
        end
    end

    // A completed frame is only dropped when the held byte is still unaccepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (w_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= r_shift;
                    frame_err  <= ~r_rx_s;
                    parity_err <= r_par_en & r_par_bad;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
